imem_responder: RTL and testbench
=================================

# imem_responder

Memory-side responder for the instruction-memory valid/ready interface driven by the fetch stage. It holds a word-addressed RAM, inserts a configurable number of wait states per request, completes each request with a single-cycle `imem_ready_o` pulse carrying read data, and applies byte-masked writes. It sits opposite `fetch_stage` in simulation tops and FPGA builds, and exposes completed-access counters for bench and performance checks.

## Interface

- `ADDR_WIDTH`, 32: request address width.
- `DATA_WIDTH`, 32: data word width; must be 32.
- `DEPTH_WORDS`, 1024: RAM depth in words; power of two, at least 2.
- `LATENCY`, 1: wait cycles between the first valid cycle and ready; 0 allowed.
- `INIT_FILE`, "": hex file loaded into RAM at elaboration; empty means no load.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_valid_i`  in  1  request present; the requester may drop it before ready (abandon).
- `imem_ready_o`  out  1  request completes this cycle; `imem_rdata_o` valid.
- `imem_addr_i`  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- `imem_wdata_i`  in  DATA_WIDTH  write data.
- `imem_we_i`  in  4  byte write enables; lane i covers bits [8i+7:8i].
- `imem_rdata_o`  out  DATA_WIDTH  read data; 0 whenever ready is low.
- `stall_i`  in  1  bench backpressure; holds off completion while high.
- `perf_reads_o`  out  32  count of completed requests with `imem_we_i == 0`.
- `perf_writes_o`  out  32  count of completed requests with `imem_we_i != 0`.

## Operation

- Word index: `imem_addr_i[IDX+1:2]`, where IDX = clog2(DEPTH_WORDS). Higher address bits are ignored, so addresses alias modulo the RAM size.
- Wait counter `cnt`, width clog2(LATENCY+1) (minimum 1). It counts consecutive valid cycles of the current request.
- Ready: `imem_ready_o = imem_valid_i && !stall_i && !rst && (cnt == LATENCY)`. It is combinational from valid. Ready is never high while valid is low; the fetch stage writes its buffer on ready alone.
- Next `cnt`:
  - 0 if `rst`, `!imem_valid_i`, or `imem_ready_o`;
  - otherwise `cnt+1` if `cnt < LATENCY`;
  - otherwise hold (stalled at the limit).
- Implicit states:
  - IDLE: `cnt == 0`, no ready.
  - WAIT: `0 < cnt`, or `cnt == LATENCY` while stalled.
  - RESP: the ready cycle, which returns to IDLE.
- Abandon: valid low in any WAIT cycle discards the request. No ready, no write, no counter increment. A later valid starts a fresh count.
- Read data is an asynchronous read of `mem[index]` using the address present in the ready cycle. The address may change during WAIT; only the ready-cycle address, wdata and we matter.
- Write: in the ready cycle, each byte lane with its enable bit set is written at the clock edge. `imem_rdata_o` in that same cycle returns the old word (read-before-write).
- Counters increment by one on each ready cycle, selected by `imem_we_i`. They wrap from 0xFFFFFFFF to 0.
- Reset clears `cnt` and both counters. RAM contents are not cleared by reset.

## Timing

- Reset values: `imem_ready_o`=0, `imem_rdata_o`=0, `perf_reads_o`=0, `perf_writes_o`=0.
- Request with first valid cycle N and no stall: ready in cycle N+LATENCY.
- LATENCY=0: ready in the same cycle as valid, so a held valid completes one word per cycle.
- Back-to-back requests: after a ready in cycle M, valid still high in M+1 (new address) is a new request and completes in M+1+LATENCY. Sustained throughput is 1/(LATENCY+1).
- Stall in the cycle where `cnt == LATENCY` delays ready cycle by cycle. Stall during earlier WAIT cycles does not slow the count.
- `rst` asserted mid-request: ready is 0 in that cycle, and the request restarts from `cnt=0` in the first cycle after `rst` deasserts if valid is still high.
- Write then read of the same word on consecutive requests: the read returns the new data.

## Test plan

- LATENCY=2, `INIT_FILE` word0=0x00000013, word1=0x00100093. Valid held at address 0x0, then 0x4 after the ready → ready in cycles 2 and 5, rdata 0x00000013 then 0x00100093, `perf_reads_o`=2.
- LATENCY=0, valid held for 8 cycles with the address stepping by 4 → ready in all 8 cycles, `perf_reads_o`=8, rdata matches each word.
- LATENCY=3, valid high for 2 cycles then low for 1, then high again → no ready in the first burst; ready on the 4th cycle of the second burst; counters unchanged by the abandoned request.
- Write 0xDEADBEEF to 0x10 with `we`=4'b0101 over RAM contents 0x11223344 → rdata in the write cycle is 0x11223344; a following read returns 0x11AD33EF; `perf_writes_o`=1.
- LATENCY=1, `stall_i` high for 3 cycles at `cnt==1` → ready delayed by exactly 3 cycles. Separately, `rst` pulsed mid-wait → no ready in the reset cycle, the count restarts, and counters return to 0.
- DEPTH_WORDS=1024, read address 0x1000 → returns word 0 (aliasing).

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder: word RAM behind a valid/ready port with
// programmable wait states, byte-masked writes and completed-access counters.
module imem_responder #(
  parameter int    ADDR_WIDTH  = 32,
  parameter int    DATA_WIDTH  = 32,
  parameter int    DEPTH_WORDS = 1024,
  parameter int    LATENCY     = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imem_valid_i,
  output logic                  imem_ready_o,
  input  logic [ADDR_WIDTH-1:0] imem_addr_i,
  input  logic [DATA_WIDTH-1:0] imem_wdata_i,
  input  logic [3:0]            imem_we_i,
  output logic [DATA_WIDTH-1:0] imem_rdata_o,
  input  logic                  stall_i,
  output logic [31:0]           perf_reads_o,
  output logic [31:0]           perf_writes_o
);
  localparam int NUM_LANES = 4;
  localparam int IDX = $clog2(DEPTH_WORDS);
  localparam int CW  = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAT = CW'(LATENCY);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           reads_q, writes_q;
  logic [IDX-1:0]        idx;
  logic                  unused_addr;

  // Upper address bits fold away, so the RAM aliases across the address space.
  assign idx         = imem_addr_i[IDX+1:2];
  assign unused_addr = ^{imem_addr_i[1:0], imem_addr_i[ADDR_WIDTH-1:IDX+2]};

  assign imem_ready_o  = imem_valid_i && !stall_i && !rst && (cnt_q == LAT);
  assign imem_rdata_o  = imem_ready_o ? mem_q[idx] : '0;
  assign perf_reads_o  = reads_q;
  assign perf_writes_o = writes_q;

  // Count consecutive valid cycles; saturate at LAT while stalled.
  always_comb begin
    cnt_d = cnt_q;
    if (!imem_valid_i || imem_ready_o) cnt_d = '0;
    else if (cnt_q < LAT)              cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      reads_q  <= '0;
      writes_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (imem_ready_o) begin
        if (imem_we_i == 4'b0) reads_q  <= reads_q + 32'd1;
        else                   writes_q <= writes_q + 32'd1;
      end
    end
  end

  // RAM is not reset; the ready-cycle read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (imem_ready_o) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (imem_we_i[i]) mem_q[idx][8*i +: 8] <= imem_wdata_i[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// Directed bench: LATENCY=2 responder driven from a vector table plus
// hand sequences, and a LATENCY=0 small-RAM responder for streaming/aliasing.
module tb_imem_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v2, st2, r2;
  logic [31:0] a2, wd2, d2, pr2, pw2;
  logic [3:0]  we2;
  logic        v0, st0, r0;
  logic [31:0] a0, wd0, d0, pr0, pw0;
  logic [3:0]  we0;

  imem_responder #(.LATENCY(2), .DEPTH_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .imem_valid_i(v2), .imem_ready_o(r2),
    .imem_addr_i(a2), .imem_wdata_i(wd2), .imem_we_i(we2),
    .imem_rdata_o(d2), .stall_i(st2), .perf_reads_o(pr2), .perf_writes_o(pw2));

  imem_responder #(.LATENCY(0), .DEPTH_WORDS(16)) dut0 (
    .clk(clk), .rst(rst), .imem_valid_i(v0), .imem_ready_o(r0),
    .imem_addr_i(a0), .imem_wdata_i(wd0), .imem_we_i(we0),
    .imem_rdata_o(d0), .stall_i(st0), .perf_reads_o(pr0), .perf_writes_o(pw0));

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    bit          chk_rd;
  } vec_t;

  vec_t tv[12];
  int   errors = 0;
  int   checks = 0;
  int   exp_rd = 0;
  int   exp_wr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sample the LATENCY=2 port one step after inputs settle.
  task automatic ex2(input string nm, input logic er, input logic [31:0] ed, input bit cd);
    #1;
    chk({nm, ".ready"}, {31'b0, r2}, {31'b0, er});
    if (!er) chk({nm, ".rdata_idle"}, d2, 32'h0);
    else if (cd) chk({nm, ".rdata"}, d2, ed);
  endtask

  task automatic ex0(input string nm, input logic er, input logic [31:0] ed, input bit cd);
    #1;
    chk({nm, ".ready"}, {31'b0, r0}, {31'b0, er});
    if (!er) chk({nm, ".rdata_idle"}, d0, 32'h0);
    else if (cd) chk({nm, ".rdata"}, d0, ed);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{4'hF, 32'h0000_0000, 32'h0000_0013, 32'h0, 1'b0};
    tv[1]  = '{4'hF, 32'h0000_0004, 32'h0010_0093, 32'h0, 1'b0};
    tv[2]  = '{4'hF, 32'h0000_0010, 32'h1122_3344, 32'h0, 1'b0};
    tv[3]  = '{4'h0, 32'h0000_0000, 32'h0,         32'h0000_0013, 1'b1};
    tv[4]  = '{4'h0, 32'h0000_0004, 32'h0,         32'h0010_0093, 1'b1};
    tv[5]  = '{4'h5, 32'h0000_0010, 32'hDEAD_BEEF, 32'h1122_3344, 1'b1};
    tv[6]  = '{4'h0, 32'h0000_0010, 32'h0,         32'h11AD_33EF, 1'b1};
    tv[7]  = '{4'h0, 32'h0000_1000, 32'h0,         32'h0000_0013, 1'b1};
    tv[8]  = '{4'h8, 32'h0000_1004, 32'hAB00_0000, 32'h0010_0093, 1'b1};
    tv[9]  = '{4'h0, 32'h0000_0004, 32'h0,         32'hAB10_0093, 1'b1};
    tv[10] = '{4'h2, 32'h0000_0000, 32'h0000_CC00, 32'h0000_0013, 1'b1};
    tv[11] = '{4'h0, 32'h0000_0000, 32'h0,         32'h0000_CC13, 1'b1};

    rst = 1'b1;
    v2 = 1'b1; a2 = '0; wd2 = '0; we2 = '0; st2 = 1'b0;
    v0 = 1'b1; a0 = '0; wd0 = '0; we0 = '0; st0 = 1'b0;
    cyc(); cyc();
    ex2("rst_l2", 1'b0, 32'h0, 1'b0);
    ex0("rst_l0", 1'b0, 32'h0, 1'b0);
    chk("rst.reads", pr2, 32'd0);
    chk("rst.writes", pw2, 32'd0);
    chk("rst.reads0", pr0, 32'd0);
    rst = 1'b0; v2 = 1'b0; v0 = 1'b0;

    // Table: one full request per vector, ready expected on the third cycle.
    for (int i = 0; i < 12; i++) begin
      cyc();
      v2 = 1'b1; a2 = tv[i].addr; wd2 = tv[i].wdata; we2 = tv[i].we;
      ex2($sformatf("tv%0d.c0", i), 1'b0, 32'h0, 1'b0);
      cyc(); ex2($sformatf("tv%0d.c1", i), 1'b0, 32'h0, 1'b0);
      cyc(); ex2($sformatf("tv%0d.c2", i), 1'b1, tv[i].rd, tv[i].chk_rd);
      if (tv[i].we == 4'h0) exp_rd++; else exp_wr++;
      cyc(); v2 = 1'b0; we2 = '0;
      ex2($sformatf("tv%0d.c3", i), 1'b0, 32'h0, 1'b0);
    end
    chk("tbl.reads", pr2, exp_rd);
    chk("tbl.writes", pw2, exp_wr);

    // Back-to-back: valid held, new address right after ready.
    cyc(); v2 = 1'b1; a2 = 32'h0; ex2("b2b.c0", 1'b0, 32'h0, 1'b0);
    cyc(); ex2("b2b.c1", 1'b0, 32'h0, 1'b0);
    cyc(); ex2("b2b.c2", 1'b1, 32'h0000_CC13, 1'b1);
    cyc(); a2 = 32'h4; ex2("b2b.c3", 1'b0, 32'h0, 1'b0);
    cyc(); ex2("b2b.c4", 1'b0, 32'h0, 1'b0);
    cyc(); ex2("b2b.c5", 1'b1, 32'hAB10_0093, 1'b1);
    cyc(); v2 = 1'b0; ex2("b2b.c6", 1'b0, 32'h0, 1'b0);
    exp_rd += 2;

    // Abandon after two valid cycles; the retry counts from zero.
    cyc(); v2 = 1'b1; a2 = 32'h0; ex2("abn.c0", 1'b0, 32'h0, 1'b0);
    cyc(); ex2("abn.c1", 1'b0, 32'h0, 1'b0);
    cyc(); v2 = 1'b0; ex2("abn.c2", 1'b0, 32'h0, 1'b0);
    cyc(); v2 = 1'b1; ex2("abn.c3", 1'b0, 32'h0, 1'b0);
    cyc(); ex2("abn.c4", 1'b0, 32'h0, 1'b0);
    cyc(); ex2("abn.c5", 1'b1, 32'h0000_CC13, 1'b1);
    cyc(); v2 = 1'b0; ex2("abn.c6", 1'b0, 32'h0, 1'b0);
    exp_rd += 1;
    chk("abn.reads", pr2, exp_rd);
    chk("abn.writes", pw2, exp_wr);

    // Stall at the limit for three cycles delays ready by exactly three.
    cyc(); v2 = 1'b1; a2 = 32'h4; ex2("stl.c0", 1'b0, 32'h0, 1'b0);
    cyc(); ex2("stl.c1", 1'b0, 32'h0, 1'b0);
    cyc(); st2 = 1'b1; ex2("stl.c2", 1'b0, 32'h0, 1'b0);
    cyc(); ex2("stl.c3", 1'b0, 32'h0, 1'b0);
    cyc(); ex2("stl.c4", 1'b0, 32'h0, 1'b0);
    cyc(); st2 = 1'b0; ex2("stl.c5", 1'b1, 32'hAB10_0093, 1'b1);
    cyc(); v2 = 1'b0; ex2("stl.c6", 1'b0, 32'h0, 1'b0);
    exp_rd += 1;

    // Stall during early wait cycles does not slow the count.
    cyc(); v2 = 1'b1; a2 = 32'h10; st2 = 1'b1; ex2("est.c0", 1'b0, 32'h0, 1'b0);
    cyc(); ex2("est.c1", 1'b0, 32'h0, 1'b0);
    cyc(); st2 = 1'b0; ex2("est.c2", 1'b1, 32'h11AD_33EF, 1'b1);
    cyc(); v2 = 1'b0; ex2("est.c3", 1'b0, 32'h0, 1'b0);
    exp_rd += 1;
    chk("stl.reads", pr2, exp_rd);

    // Reset mid-wait: suppressed ready, counters cleared, count restarts.
    cyc(); v2 = 1'b1; a2 = 32'h4; ex2("rmw.c0", 1'b0, 32'h0, 1'b0);
    cyc(); ex2("rmw.c1", 1'b0, 32'h0, 1'b0);
    cyc(); rst = 1'b1; ex2("rmw.c2", 1'b0, 32'h0, 1'b0);
    cyc(); rst = 1'b0; ex2("rmw.c3", 1'b0, 32'h0, 1'b0);
    chk("rmw.reads", pr2, 32'd0);
    chk("rmw.writes", pw2, 32'd0);
    cyc(); ex2("rmw.c4", 1'b0, 32'h0, 1'b0);
    cyc(); ex2("rmw.c5", 1'b1, 32'hAB10_0093, 1'b1);
    cyc(); v2 = 1'b0; ex2("rmw.c6", 1'b0, 32'h0, 1'b0);
    chk("rmw.reads1", pr2, 32'd1);

    // LATENCY=0: held valid completes one word per cycle.
    cyc(); v0 = 1'b1; we0 = 4'hF;
    for (int i = 0; i < 8; i++) begin
      a0 = 32'(4 * i); wd0 = 32'hA500_0000 | 32'(i * 17);
      ex0($sformatf("l0w%0d", i), 1'b1, 32'h0, 1'b0);
      cyc();
    end
    we0 = 4'h0;
    for (int i = 0; i < 8; i++) begin
      a0 = 32'(4 * i);
      ex0($sformatf("l0r%0d", i), 1'b1, 32'hA500_0000 | 32'(i * 17), 1'b1);
      cyc();
    end
    a0 = 32'h40;
    ex0("l0alias", 1'b1, 32'hA500_0000, 1'b1);
    cyc(); v0 = 1'b0;
    ex0("l0idle", 1'b0, 32'h0, 1'b0);
    chk("l0.reads", pr0, 32'd9);
    chk("l0.writes", pw0, 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
